enemy_spawn_scheduler: RTL and testbench

Game-flow controller that sequences the two enemy car slots on the racetrack. It runs the IDLE/RUN/CRASH state machine and schedules the staggered initial spawns and later respawns, arbitrating between the two slots. It also picks spawn lanes from the LFSR bits, ramps the enemy-speed accelerator per level, and counts dodged enemies. It sits between the random generators, the collision ALU and the enemy instances, and drives the enemy enable/position inputs and the enemy clock divider's accelerator input.

---
 rtl/enemy_spawn_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_enemy_spawn_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_spawn_scheduler.sv
// Game-flow controller: IDLE/RUN/CRASH sequencing, staggered and round-robin enemy spawns,
// lane picking, per-level accelerator ramp and dodge score.
module enemy_spawn_scheduler #(
    parameter int unsigned SPAWN_GAP   = 14,
    parameter int unsigned LEVEL_TICKS = 50,
    parameter int unsigned ACCEL_STEP  = 1000,
    parameter int unsigned ACCEL_MAX   = 100000,
    parameter int unsigned OFFSCREEN_Y = 600,
    parameter int unsigned SPAWN_Y     = 610,
    parameter int unsigned LANE_L      = 197,
    parameter int unsigned LANE_C      = 279,
    parameter int unsigned LANE_R      = 361
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        start_i,
    input  logic        collision_i,
    input  logic [2:0]  rnd_i,
    input  logic [9:0]  enemy0_y_i,
    input  logic [9:0]  enemy1_y_i,
    output logic        spawn0_o,
    output logic        spawn1_o,
    output logic [9:0]  spawn_x_o,
    output logic [9:0]  spawn_y_o,
    output logic [24:0] accel_o,
    output logic [3:0]  level_o,
    output logic [15:0] score_o,
    output logic        running_o,
    output logic        crashed_o
);
    localparam int unsigned     LvlW      = $clog2(LEVEL_TICKS + 1);
    localparam logic [5:0]      Init1Tick = 6'(SPAWN_GAP + 1);
    localparam logic [LvlW-1:0] LvlWrap   = LvlW'(LEVEL_TICKS);
    localparam logic [25:0]     AccelMax  = 26'(ACCEL_MAX);
    localparam logic [25:0]     AccelStep = 26'(ACCEL_STEP);
    localparam logic [9:0]      OffY      = 10'(OFFSCREEN_Y);
    localparam logic [1:0]      LaneL     = 2'd0;
    localparam logic [1:0]      LaneC     = 2'd1;
    localparam logic [1:0]      LaneR     = 2'd2;

    typedef enum logic [1:0] {StIdle, StRun, StCrash} state_e;

    state_e          state_q, state_d;
    logic [5:0]      tick_cnt_q, tick_cnt_d;
    logic [LvlW-1:0] lvl_cnt_q, lvl_cnt_d;
    logic [1:0]      live_q, live_d;
    logic [1:0]      started_q, started_d;
    logic [1:0]      last_lane_q, last_lane_d;
    logic            rr_q, rr_d;
    logic            spawn0_q, spawn0_d;
    logic            spawn1_q, spawn1_d;
    logic [9:0]      spawn_x_q, spawn_x_d;
    logic [24:0]     accel_q, accel_d;
    logic [3:0]      level_q, level_d;
    logic [15:0]     score_q, score_d;

    logic [1:0]      off, init, req, grant, base_lane, lane;
    logic [5:0]      tick_cnt_inc;
    logic [LvlW-1:0] lvl_cnt_inc;
    logic [16:0]     score_sum;
    logic [25:0]     accel_sum;
    logic [9:0]      lane_x;

    assign off          = live_q & {enemy1_y_i >= OffY, enemy0_y_i >= OffY};
    assign score_sum    = {1'b0, score_q} + 17'(off[0]) + 17'(off[1]);
    assign accel_sum    = {1'b0, accel_q} + AccelStep;
    assign tick_cnt_inc = (tick_cnt_q == 6'd63) ? tick_cnt_q : tick_cnt_q + 6'd1;
    assign lvl_cnt_inc  = lvl_cnt_q + LvlW'(1);
    assign init         = {tick_cnt_inc == Init1Tick, tick_cnt_inc == 6'd1};
    // Requests use the registered live bits; an off-screen clear counts from the next tick.
    assign req          = (started_q | init) & ~live_q;
    assign grant        = (req == 2'b11) ? (rr_q ? 2'b01 : 2'b10) : req;

    always_comb begin
        case (rnd_i)
            3'd0, 3'd3, 3'd6: base_lane = LaneL;
            3'd1, 3'd4, 3'd7: base_lane = LaneC;
            default:          base_lane = LaneR;
        endcase
    end

    assign lane = (base_lane != last_lane_q) ? base_lane :
                  (base_lane == LaneR) ? LaneL : base_lane + 2'd1;

    always_comb begin
        case (lane)
            LaneL:   lane_x = 10'(LANE_L);
            LaneC:   lane_x = 10'(LANE_C);
            default: lane_x = 10'(LANE_R);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        lvl_cnt_d   = lvl_cnt_q;
        live_d      = live_q;
        started_d   = started_q;
        last_lane_d = last_lane_q;
        rr_d        = rr_q;
        spawn0_d    = 1'b0;
        spawn1_d    = 1'b0;
        spawn_x_d   = spawn_x_q;
        accel_d     = accel_q;
        level_d     = level_q;
        score_d     = score_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun: begin
                live_d  = live_q & ~off;
                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                if (collision_i) begin
                    state_d = StCrash;
                end else if (tick_i) begin
                    tick_cnt_d = tick_cnt_inc;
                    started_d  = started_q | init;
                    spawn0_d   = grant[0];
                    spawn1_d   = grant[1];
                    live_d     = live_d | grant;
                    if (grant != 2'b00) begin
                        rr_d        = grant[1];
                        last_lane_d = lane;
                        spawn_x_d   = lane_x;
                    end
                    if (lvl_cnt_inc == LvlWrap) begin
                        lvl_cnt_d = '0;
                        level_d   = (level_q == 4'hF) ? level_q : level_q + 4'd1;
                        accel_d   = (accel_sum >= AccelMax) ? AccelMax[24:0] : accel_sum[24:0];
                    end else begin
                        lvl_cnt_d = lvl_cnt_inc;
                    end
                end
            end
            StCrash: begin
                if (start_i) begin
                    state_d    = StRun;
                    tick_cnt_d = '0;
                    lvl_cnt_d  = '0;
                    live_d     = '0;
                    started_d  = '0;
                    accel_d    = '0;
                    level_d    = '0;
                    score_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            lvl_cnt_q   <= '0;
            live_q      <= '0;
            started_q   <= '0;
            last_lane_q <= LaneC;
            rr_q        <= 1'b0;
            spawn0_q    <= 1'b0;
            spawn1_q    <= 1'b0;
            spawn_x_q   <= 10'(LANE_C);
            accel_q     <= '0;
            level_q     <= '0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            lvl_cnt_q   <= lvl_cnt_d;
            live_q      <= live_d;
            started_q   <= started_d;
            last_lane_q <= last_lane_d;
            rr_q        <= rr_d;
            spawn0_q    <= spawn0_d;
            spawn1_q    <= spawn1_d;
            spawn_x_q   <= spawn_x_d;
            accel_q     <= accel_d;
            level_q     <= level_d;
            score_q     <= score_d;
        end
    end

    assign spawn0_o  = spawn0_q;
    assign spawn1_o  = spawn1_q;
    assign spawn_x_o = spawn_x_q;
    assign spawn_y_o = 10'(SPAWN_Y);
    assign accel_o   = accel_q;
    assign level_o   = level_q;
    assign score_o   = score_q;
    assign running_o = (state_q == StRun);
    assign crashed_o = (state_q == StCrash);

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed plus randomized bench for enemy_spawn_scheduler, checked every cycle against
// a behavioural game-flow model.
module tb_enemy_spawn_scheduler;
    localparam int SPAWN_GAP = 14;

    logic        clk = 1'b0;
    logic        reset, tick, start, collision;
    logic [2:0]  rnd;
    logic [9:0]  y0, y1;
    logic        spawn0, spawn1, running, crashed;
    logic [9:0]  spawn_x, spawn_y;
    logic [24:0] accel;
    logic [3:0]  level;
    logic [15:0] score;

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 idle, 1 run, 2 crash; m_ups counts completed levels, unbounded.
    int m_state, m_ticks, m_lvl_ticks, m_ups, m_score, m_last, m_rr, e_x, saved;
    bit m_live [2];
    bit m_started [2];
    bit e_sp0, e_sp1;
    int lanes [3] = '{197, 279, 361};

    always #5 clk = ~clk;

    enemy_spawn_scheduler dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .tick_i      (tick),
        .start_i     (start),
        .collision_i (collision),
        .rnd_i       (rnd),
        .enemy0_y_i  (y0),
        .enemy1_y_i  (y1),
        .spawn0_o    (spawn0),
        .spawn1_o    (spawn1),
        .spawn_x_o   (spawn_x),
        .spawn_y_o   (spawn_y),
        .accel_o     (accel),
        .level_o     (level),
        .score_o     (score),
        .running_o   (running),
        .crashed_o   (crashed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit gone0, gone1, want0, want1;
        int w, base;
        e_sp0 = 1'b0;
        e_sp1 = 1'b0;
        if (reset) begin
            m_state = 0; m_ticks = 0; m_lvl_ticks = 0; m_ups = 0; m_score = 0;
            m_live = '{0, 0}; m_started = '{0, 0}; m_last = 1; m_rr = 0; e_x = 279;
        end else begin
            case (m_state)
                0: if (start) m_state = 1;
                1: begin
                    want0 = !m_live[0];
                    want1 = !m_live[1];
                    gone0 = m_live[0] && (y0 >= 600);
                    gone1 = m_live[1] && (y1 >= 600);
                    if (gone0) m_live[0] = 1'b0;
                    if (gone1) m_live[1] = 1'b0;
                    m_score = m_score + int'(gone0) + int'(gone1);
                    if (m_score > 65535) m_score = 65535;
                    if (collision) begin
                        m_state = 2;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == 1) m_started[0] = 1'b1;
                        if (m_ticks == SPAWN_GAP + 1) m_started[1] = 1'b1;
                        want0 = want0 && m_started[0];
                        want1 = want1 && m_started[1];
                        w = -1;
                        if (want0 && want1) w = 1 - m_rr;
                        else if (want0) w = 0;
                        else if (want1) w = 1;
                        if (w >= 0) begin
                            base = int'(rnd) % 3;
                            if (base == m_last) base = (base + 1) % 3;
                            m_last = base;
                            e_x = lanes[base];
                            m_rr = w;
                            m_live[w] = 1'b1;
                            if (w == 0) e_sp0 = 1'b1;
                            else e_sp1 = 1'b1;
                        end
                        m_lvl_ticks++;
                        if (m_lvl_ticks == 50) begin
                            m_lvl_ticks = 0;
                            m_ups++;
                        end
                    end
                end
                default: if (start) begin
                    m_state = 1; m_ticks = 0; m_lvl_ticks = 0; m_ups = 0; m_score = 0;
                    m_live = '{0, 0}; m_started = '{0, 0};
                end
            endcase
        end
    endtask

    task automatic cycle();
        int exp_accel, exp_level;
        model_step();
        exp_accel = (m_ups * 1000 > 100000) ? 100000 : m_ups * 1000;
        exp_level = (m_ups > 15) ? 15 : m_ups;
        @(posedge clk);
        #1;
        check("spawn0", spawn0, e_sp0);
        check("spawn1", spawn1, e_sp1);
        check("spawn_x", spawn_x, e_x);
        check("spawn_y", spawn_y, 610);
        check("accel", accel, exp_accel);
        check("level", level, exp_level);
        check("score", score, m_score);
        check("running", running, m_state == 1);
        check("crashed", crashed, m_state == 2);
    endtask

    function automatic logic [9:0] rand_y();
        if ($urandom_range(0, 9) == 0) return 10'($urandom_range(600, 1023));
        return 10'($urandom_range(0, 599));
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; collision = 1'b0;
        rnd = 3'd0; y0 = 10'd100; y1 = 10'd100;
        cycle();
        cycle();
        check("rst_spawn_x", spawn_x, 279);
        check("rst_running", running, 0);

        reset = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        check("start_running", running, 1);
        cycle();

        tick = 1'b1; rnd = 3'd3;
        cycle();
        tick = 1'b0;
        check("first_spawn0", spawn0, 1);
        check("first_x", spawn_x, 197);
        cycle();
        check("spawn0_one_clk", spawn0, 0);

        for (int i = 2; i <= SPAWN_GAP; i++) begin
            rnd = 3'($urandom_range(0, 7));
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            cycle();
        end
        tick = 1'b1; rnd = 3'd3;
        cycle();
        tick = 1'b0;
        check("slot1_spawn", spawn1, 1);
        check("slot1_x_rotated", spawn_x, 279);
        check("slot1_no_spawn0", spawn0, 0);
        cycle();

        y0 = 10'd600; y1 = 10'd600;
        cycle();
        check("score_both_off", score, 2);
        y0 = 10'd100; y1 = 10'd100;
        tick = 1'b1; rnd = 3'($urandom_range(0, 7));
        cycle();
        tick = 1'b0;
        check("arb_one_grant", 32'(spawn0) + 32'(spawn1), 1);
        cycle();
        tick = 1'b1; rnd = 3'($urandom_range(0, 7));
        cycle();
        tick = 1'b0;
        check("arb_loser_next", 32'(spawn0) + 32'(spawn1), 1);
        cycle();

        for (int n = 0; n < 5200; n++) begin
            rnd = 3'($urandom_range(0, 7));
            y0 = rand_y(); y1 = rand_y();
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            y0 = rand_y(); y1 = rand_y();
            cycle();
        end
        check("accel_sat", accel, 100000);
        check("level_sat", level, 15);

        y0 = 10'd700; y1 = 10'd700;
        cycle();
        y0 = 10'd100; y1 = 10'd100;
        tick = 1'b1; collision = 1'b1;
        cycle();
        tick = 1'b0; collision = 1'b0;
        check("crash_no_spawn", 32'(spawn0) + 32'(spawn1), 0);
        check("crash_flag", crashed, 1);
        saved = m_score;
        for (int n = 0; n < 20; n++) begin
            tick = n[0];
            y0 = rand_y(); y1 = rand_y();
            cycle();
        end
        tick = 1'b0;
        check("score_frozen", score, saved);
        check("accel_frozen", accel, 100000);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("restart_running", running, 1);
        check("restart_score", score, 0);
        check("restart_accel", accel, 0);

        y0 = 10'd100; y1 = 10'd100;
        tick = 1'b1; reset = 1'b1;
        cycle();
        tick = 1'b0; reset = 1'b0;
        check("rst_drop_spawn", spawn0, 0);
        check("rst_mid_running", running, 0);
        check("rst_mid_x", spawn_x, 279);
        cycle();
        check("rst_no_late_spawn", spawn0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
